fifo_ctrl: RTL and testbench

- Sequencing controller for the 8 × 32-bit register file. Together the two blocks form an 8-deep synchronous FIFO.
- Accepts push/pop requests and converts them into register-file write enable, write address and read address, using head and tail pointers.
- Latches popped data.
- Reports full, empty, occupancy, and per-request ack/error status through a small result state machine.

---
 rtl/fifo_pkg.sv | 51 +++++
 rtl/fifo_ptr.sv | 63 ++++++
 rtl/fifo_ctrl.sv | 119 +++++++++++
 tb/tb_fifo_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO sequencing controller: size defaults,
// result-state encoding and the state-to-status decode.
package fifo_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int AW_DEF    = 3;
    localparam int DW_DEF    = 32;

    // Result state: records what happened to the previous cycle's requests.
    typedef logic [2:0] fifo_state_t;

    localparam fifo_state_t ST_IDLE    = 3'd0;
    localparam fifo_state_t ST_WRITE   = 3'd1;
    localparam fifo_state_t ST_READ    = 3'd2;
    localparam fifo_state_t ST_WR_RD   = 3'd3;
    localparam fifo_state_t ST_WR_ERR  = 3'd4;
    localparam fifo_state_t ST_RD_ERR  = 3'd5;
    localparam fifo_state_t ST_FULL_RD = 3'd6;

    typedef struct packed {
        logic wr_ack;
        logic wr_err;
        logic rd_ack;
        logic rd_err;
    } fifo_status_t;

    // RD_ERR alone cannot tell whether a push went through in the same
    // cycle, so the caller supplies that as a side flag.
    function automatic fifo_status_t decode_status(input fifo_state_t st,
                                                   input logic        rd_err_push);
        fifo_status_t s;
        s = '0;
        case (st)
            ST_WRITE:   s.wr_ack = 1'b1;
            ST_READ:    s.rd_ack = 1'b1;
            ST_WR_RD,
            ST_FULL_RD: begin
                s.wr_ack = 1'b1;
                s.rd_ack = 1'b1;
            end
            ST_WR_ERR:  s.wr_err = 1'b1;
            ST_RD_ERR:  begin
                s.rd_err = 1'b1;
                s.wr_ack = rd_err_push;
            end
            default:    s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Head/tail pointer and occupancy storage for the 8-deep FIFO.
// Takes already-resolved push/pop decisions; never rejects anything itself.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_i,
    input  logic          pop_i,
    output logic [AW-1:0] head_o,
    output logic [AW-1:0] tail_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;

    // Explicit wrap so a non-power-of-two DEPTH still cycles correctly.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Next pointers and occupancy; a simultaneous push+pop leaves count alone.
    always_comb begin
        head_d  = pop_i  ? ptr_inc(head_q) : head_q;
        tail_d  = push_i ? ptr_inc(tail_q) : tail_q;
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign count_o = count_q;
    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fifo_ctrl.sv
// Sequencing controller for an external 8 x 32 register file. Resolves
// push/pop requests, drives the register-file write/read ports, latches
// popped data and reports per-request outcome one cycle later.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic [DW-1:0] rf_rdata,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [AW-1:0] rf_raddr,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   data_count,
    output logic          wr_ack,
    output logic          wr_err,
    output logic          rd_ack,
    output logic          rd_err
);

    logic          push_acc;
    logic          pop_acc;
    logic          full_w;
    logic          empty_w;
    logic [AW-1:0] head_w;
    logic [AW-1:0] tail_w;
    logic [AW:0]   count_w;

    fifo_state_t   state_q, state_d;
    logic          rd_err_push_q, rd_err_push_d;
    logic [DW-1:0] dout_q, dout_d;
    fifo_status_t  status;

    // Request resolution. A pop frees a slot this cycle, so a push is still
    // taken while full if a pop comes with it; the write then lands on the
    // slot being read (tail == head) and the read sees the old value.
    // Gating with reset_n keeps requests made during reset from writing.
    always_comb begin
        push_acc = reset_n & wr_en & (~full_w | rd_en);
        pop_acc  = reset_n & rd_en & ~empty_w;
    end

    fifo_ptr #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push_acc),
        .pop_i   (pop_acc),
        .head_o  (head_w),
        .tail_o  (tail_w),
        .count_o (count_w),
        .full_o  (full_w),
        .empty_o (empty_w)
    );

    // Outcome classification for this cycle's requests; becomes the state.
    always_comb begin
        state_d       = ST_IDLE;
        rd_err_push_d = 1'b0;
        if (rd_en && empty_w) begin
            state_d       = ST_RD_ERR;
            rd_err_push_d = push_acc;
        end else if (push_acc && pop_acc) begin
            state_d = full_w ? ST_FULL_RD : ST_WR_RD;
        end else if (push_acc) begin
            state_d = ST_WRITE;
        end else if (pop_acc) begin
            state_d = ST_READ;
        end else if (wr_en) begin
            state_d = ST_WR_ERR;
        end
    end

    // Popped data holds until the next accepted pop.
    always_comb begin
        dout_d = pop_acc ? rf_rdata : dout_q;
    end

    // Result state, its push side-flag and the output data register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            rd_err_push_q <= 1'b0;
            dout_q        <= '0;
        end else begin
            state_q       <= state_d;
            rd_err_push_q <= rd_err_push_d;
            dout_q        <= dout_d;
        end
    end

    // Status decode from the registered state.
    always_comb begin
        status = decode_status(state_q, rd_err_push_q);
    end

    assign rf_we      = push_acc;
    assign rf_waddr   = tail_w;
    assign rf_raddr   = head_w;
    assign dout       = dout_q;
    assign full       = full_w;
    assign empty      = empty_w;
    assign data_count = count_w;
    assign wr_ack     = status.wr_ack;
    assign wr_err     = status.wr_err;
    assign rd_ack     = status.rd_ack;
    assign rd_err     = status.rd_err;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: hosts a behavioural register file, replays a
// directed vector table, then hand sequences and random traffic checked
// against a queue-based FIFO model.
module tb_fifo_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rf_rdata;
    logic        rf_we;
    logic [2:0]  rf_waddr, rf_raddr;
    logic [31:0] dout;
    logic        full, empty;
    logic [3:0]  data_count;
    logic        wr_ack, wr_err, rd_ack, rd_err;

    logic [31:0] rf_mem [8];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fifo_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .rf_rdata   (rf_rdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_raddr   (rf_raddr),
        .dout       (dout),
        .full       (full),
        .empty      (empty),
        .data_count (data_count),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err)
    );

    // Register file: synchronous write, combinational read.
    assign rf_rdata = rf_mem[rf_raddr];
    always @(posedge clk) if (rf_we) rf_mem[rf_waddr] <= wdata;

    typedef struct {
        bit          we;
        int          cnt;
        bit          ful, emp;
        bit          wa, werr, ra, rerr;
        logic [31:0] dout;
    } exp_t;

    typedef struct {
        bit          rst, wr, rd;
        logic [31:0] d;
        exp_t        e;
    } vec_t;

    // Reference model: plain queue of stored words plus last popped value.
    logic [31:0] mq[$];
    logic [31:0] mdout = '0;

    task automatic model(input bit rst, input bit wr, input bit rd,
                         input logic [31:0] d, output exp_t m);
        bit f, e, pa, po;
        m = '{default: 0};
        if (!rst) begin
            mq.delete();
            mdout = '0;
        end else begin
            f  = (mq.size() == 8);
            e  = (mq.size() == 0);
            pa = wr && (!f || rd);
            po = rd && !e;
            if (po) mdout = mq.pop_front();
            if (pa) mq.push_back(d);
            m.we   = pa;
            m.wa   = pa;
            m.werr = wr && !pa;
            m.ra   = po;
            m.rerr = rd && !po;
        end
        m.cnt  = mq.size();
        m.ful  = (m.cnt == 8);
        m.emp  = (m.cnt == 0);
        m.dout = mdout;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check rf_we in-cycle, check registered
    // outputs at the following negedge. Table expectations override the model.
    task automatic step(input bit rst, input bit wr, input bit rd, input logic [31:0] d,
                        input bit use_tab, input exp_t tab);
        exp_t m, e;
        reset_n = rst; wr_en = wr; rd_en = rd; wdata = d;
        model(rst, wr, rd, d, m);
        e = use_tab ? tab : m;
        #1;
        chk("rf_we", 32'(rf_we), 32'(e.we));
        @(posedge clk);
        @(negedge clk);
        chk("data_count", 32'(data_count), 32'(e.cnt));
        chk("full",   32'(full),   32'(e.ful));
        chk("empty",  32'(empty),  32'(e.emp));
        chk("wr_ack", 32'(wr_ack), 32'(e.wa));
        chk("wr_err", 32'(wr_err), 32'(e.werr));
        chk("rd_ack", 32'(rd_ack), 32'(e.ra));
        chk("rd_err", 32'(rd_err), 32'(e.rerr));
        chk("dout",   dout,        e.dout);
    endtask

    task automatic mstep(input bit rst, input bit wr, input bit rd, input logic [31:0] d);
        exp_t dummy;
        dummy = '{default: 0};
        step(rst, wr, rd, d, 1'b0, dummy);
    endtask

    function automatic vec_t mk(bit rst, bit wr, bit rd, logic [31:0] d, bit we, int cnt,
                                bit wa, bit werr, bit ra, bit rerr, logic [31:0] dv);
        vec_t v;
        v.rst = rst; v.wr = wr; v.rd = rd; v.d = d;
        v.e.we = we; v.e.cnt = cnt; v.e.ful = (cnt == 8); v.e.emp = (cnt == 0);
        v.e.wa = wa; v.e.werr = werr; v.e.ra = ra; v.e.rerr = rerr; v.e.dout = dv;
        return v;
    endfunction

    initial begin
        vec_t tab[$];

        for (int i = 0; i < 8; i++) rf_mem[i] = '0;

        // Directed table: reset, idle, fill, overflow, drain, underflow,
        // then simultaneous push+pop on an empty FIFO.
        tab.push_back(mk(0, 1, 1, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 8; k++)
            tab.push_back(mk(1, 1, 0, 32'(k * 'h11), 1, k, 1, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 0, 32'h99, 0, 8, 0, 1, 0, 0, 0));
        for (int k = 1; k <= 8; k++)
            tab.push_back(mk(1, 0, 1, 0, 0, 8 - k, 0, 0, 1, 0, 32'(k * 'h11)));
        tab.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h88));
        tab.push_back(mk(1, 1, 1, 32'hAA, 1, 1, 1, 0, 0, 1, 32'h88));

        @(negedge clk);
        foreach (tab[i]) step(tab[i].rst, tab[i].wr, tab[i].rd, tab[i].d, 1'b1, tab[i].e);

        // Drain 0xAA, then wrap: push 5 / pop 5 / push 6 / pop 6.
        mstep(1, 0, 1, 0);
        for (int i = 0; i < 5; i++) mstep(1, 1, 0, 32'h500 + i);
        for (int i = 0; i < 5; i++) mstep(1, 0, 1, 0);
        for (int i = 0; i < 6; i++) mstep(1, 1, 0, 32'h600 + i);
        for (int i = 0; i < 6; i++) mstep(1, 0, 1, 0);

        // Full with simultaneous push+pop, then drain to check ordering.
        for (int i = 0; i < 8; i++) mstep(1, 1, 0, 32'hC00 + i);
        mstep(1, 1, 1, 32'hCFF);
        mstep(1, 1, 1, 32'hCFE);
        for (int i = 0; i < 9; i++) mstep(1, 0, 1, 0);

        // Reset mid-stream at count 4 with wr_en high, then idle.
        for (int i = 0; i < 4; i++) mstep(1, 1, 0, 32'hD00 + i);
        mstep(0, 1, 0, 32'hDFF);
        mstep(1, 0, 0, 0);
        mstep(1, 0, 1, 0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            bit r, w, d;
            r = ($urandom_range(0, 99) != 0);
            w = ($urandom_range(0, 99) < 55);
            d = ($urandom_range(0, 99) < 50);
            mstep(r, w, d, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
